// File: rtl/memory_bus_arbiter.sv
// memory_bus_arbiter
//   Two-requester arbiter that shares the single-ported ram between the instruction-fetch
//   path (I) and the load/store path (D). Requests are latched, one transaction at a time
//   is sequenced onto the memory bus, and the result is returned to the winner with a
//   4-phase level handshake (the same handshake ram uses).
//
//   Configuration macro: ARBITER_ROUND_ROBIN_EN
//     undefined : fixed priority, D beats I when both are pending.
//     defined   : on a tie, the port that did not win last time is granted.
//
// Ports
//   clock, reset        single rising-edge clock; asynchronous active-low reset
//   i_read/i_address    I read request (level) and address
//   i_data/i_ready      I read data and completion (held until i_read drops)
//   d_read/d_write      D read / write request (level); read wins if both are high
//   d_address/d_wdata   D address and write data
//   d_rdata/d_ready     D read data and read completion
//   d_done              D write completion
//   m_read/m_write      strobes to ram
//   m_address/m_wdata   address / write data to ram
//   m_rdata/m_ready     read data and read completion from ram
//   m_done              write completion from ram
//   grant               one-hot owner: [0]=I, [1]=D; 00 when idle
module memory_bus_arbiter #(
    parameter int unsigned XLEN           = 32,
    parameter int unsigned BUS_WIDTH_BITS = 256
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      i_read,
    input  logic [XLEN-1:0]           i_address,
    output logic [BUS_WIDTH_BITS-1:0] i_data,
    output logic                      i_ready,
    input  logic                      d_read,
    input  logic                      d_write,
    input  logic [XLEN-1:0]           d_address,
    input  logic [BUS_WIDTH_BITS-1:0] d_wdata,
    output logic [BUS_WIDTH_BITS-1:0] d_rdata,
    output logic                      d_ready,
    output logic                      d_done,
    output logic                      m_read,
    output logic                      m_write,
    output logic [XLEN-1:0]           m_address,
    output logic [BUS_WIDTH_BITS-1:0] m_wdata,
    input  logic [BUS_WIDTH_BITS-1:0] m_rdata,
    input  logic                      m_ready,
    input  logic                      m_done,
    output logic [1:0]                grant
);

    typedef enum logic [1:0] {StIdle, StAccess, StRespond} state_e;

    state_e                    state_q, state_d;
    logic                      i_req_q, d_rd_q, d_wr_q;
    logic [1:0]                grant_q, grant_d;
    logic                      op_write_q, op_write_d;
    logic [XLEN-1:0]           addr_q, addr_d;
    logic [BUS_WIDTH_BITS-1:0] wdata_q, wdata_d;
    logic [BUS_WIDTH_BITS-1:0] i_data_q, i_data_d;
    logic [BUS_WIDTH_BITS-1:0] d_rdata_q, d_rdata_d;
    logic                      pick_d;
    logic                      winner_req;

`ifdef ARBITER_ROUND_ROBIN_EN
    logic last_grant_q, last_grant_d;  // 0 = I won last, 1 = D won last

    // Single requests win outright; on a tie the previous loser is served.
    assign pick_d = (d_rd_q | d_wr_q) & (~i_req_q | ~last_grant_q);
`else
    assign pick_d = d_rd_q | d_wr_q;
`endif

    // Completion is released only by the winner's own request level.
    assign winner_req = grant_q[0] ? i_read : (d_read | d_write);

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= StIdle;
            i_req_q      <= 1'b0;
            d_rd_q       <= 1'b0;
            d_wr_q       <= 1'b0;
            grant_q      <= 2'b00;
            op_write_q   <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            i_data_q     <= '0;
            d_rdata_q    <= '0;
`ifdef ARBITER_ROUND_ROBIN_EN
            last_grant_q <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            i_req_q      <= i_read;
            d_rd_q       <= d_read;
            d_wr_q       <= d_write;
            grant_q      <= grant_d;
            op_write_q   <= op_write_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            i_data_q     <= i_data_d;
            d_rdata_q    <= d_rdata_d;
`ifdef ARBITER_ROUND_ROBIN_EN
            last_grant_q <= last_grant_d;
`endif
        end
    end

    // Next-state logic
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        op_write_d   = op_write_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        i_data_d     = i_data_q;
        d_rdata_d    = d_rdata_q;
`ifdef ARBITER_ROUND_ROBIN_EN
        last_grant_d = last_grant_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (i_req_q | d_rd_q | d_wr_q) begin
                    state_d    = StAccess;
                    grant_d    = pick_d ? 2'b10 : 2'b01;
                    // A simultaneous d_read/d_write is treated as a read.
                    op_write_d = pick_d & ~d_rd_q;
                    addr_d     = pick_d ? d_address : i_address;
                    if (pick_d) begin
                        wdata_d = d_wdata;
                    end
`ifdef ARBITER_ROUND_ROBIN_EN
                    last_grant_d = pick_d;
`endif
                end
            end
            StAccess: begin
                if (!op_write_q && m_ready) begin
                    state_d = StRespond;
                    if (grant_q[0]) begin
                        i_data_d = m_rdata;
                    end else begin
                        d_rdata_d = m_rdata;
                    end
                end else if (op_write_q && m_done) begin
                    state_d = StRespond;
                end
            end
            StRespond: begin
                // Waiting for ram to drop its level keeps a stale m_ready/m_done
                // from completing the next transaction.
                if (!winner_req && !m_ready && !m_done) begin
                    state_d = StIdle;
                    grant_d = 2'b00;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs
    always_comb begin
        m_read    = (state_q == StAccess) & ~op_write_q;
        m_write   = (state_q == StAccess) & op_write_q;
        i_ready   = (state_q == StRespond) & grant_q[0];
        d_ready   = (state_q == StRespond) & grant_q[1] & ~op_write_q;
        d_done    = (state_q == StRespond) & grant_q[1] & op_write_q;
        m_address = addr_q;
        m_wdata   = wdata_q;
        grant     = grant_q;
        i_data    = i_data_q;
        d_rdata   = d_rdata_q;
    end

endmodule

// File: tb/tb_memory_bus_arbiter.sv
// Testbench for memory_bus_arbiter: a behavioural ram, concurrent requester tasks and a
// reference model (memory array plus arbitration rule) predicting data and grant order.
module tb_memory_bus_arbiter;

    localparam int XLEN = 32;
    localparam int BW   = 256;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          i_read = 1'b0;
    logic [31:0]   i_address = '0;
    logic [BW-1:0] i_data;
    logic          i_ready;
    logic          d_read = 1'b0;
    logic          d_write = 1'b0;
    logic [31:0]   d_address = '0;
    logic [BW-1:0] d_wdata = '0;
    logic [BW-1:0] d_rdata;
    logic          d_ready, d_done;
    logic          m_read, m_write;
    logic [31:0]   m_address;
    logic [BW-1:0] m_wdata;
    logic [BW-1:0] m_rdata = '0;
    logic          m_ready = 1'b0;
    logic          m_done = 1'b0;
    logic [1:0]    grant;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    memory_bus_arbiter #(.XLEN(XLEN), .BUS_WIDTH_BITS(BW)) dut (
        .clock(clock), .reset(reset),
        .i_read(i_read), .i_address(i_address), .i_data(i_data), .i_ready(i_ready),
        .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ready(d_ready), .d_done(d_done),
        .m_read(m_read), .m_write(m_write), .m_address(m_address), .m_wdata(m_wdata),
        .m_rdata(m_rdata), .m_ready(m_ready), .m_done(m_done), .grant(grant)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    function automatic logic [7:0] idx(input logic [31:0] a);
        return a[12:5];
    endfunction

    function automatic logic [BW-1:0] default_word(input logic [7:0] i);
        if (i == 8'd2) return {32{8'hAA}};
        return {8{24'hC0FFEE, i}};
    endfunction

    // Behavioural ram: registered level handshake, ready/done drop a cycle after the strobe.
    logic [BW-1:0] ram_mem [0:255];
    bit            ram_wr  [0:255];
    always @(posedge clock) begin
        if (m_read) begin
            if (!m_ready) begin
                m_rdata <= ram_wr[idx(m_address)] ? ram_mem[idx(m_address)]
                                                  : default_word(idx(m_address));
                m_ready <= 1'b1;
            end
        end else begin
            m_ready <= 1'b0;
        end
        if (m_write) begin
            if (!m_done) begin
                ram_mem[idx(m_address)] <= m_wdata;
                ram_wr[idx(m_address)]  <= 1'b1;
                m_done                  <= 1'b1;
            end
        end else begin
            m_done <= 1'b0;
        end
    end

    // Reference model: expected memory contents and arbitration history.
    logic [BW-1:0] ref_mem [0:255];
    bit            ref_wr  [0:255];
`ifdef ARBITER_ROUND_ROBIN_EN
    bit model_last_d = 1'b0;
`endif

    function automatic logic [BW-1:0] ref_rd(input logic [31:0] a);
        return ref_wr[idx(a)] ? ref_mem[idx(a)] : default_word(idx(a));
    endfunction

    task automatic ref_write(input logic [31:0] a, input logic [BW-1:0] v);
        ref_mem[idx(a)] = v;
        ref_wr[idx(a)]  = 1'b1;
    endtask

    // Returns 1 when D is expected to win given which ports are pending.
    function automatic bit model_pick_d(input bit i_p, input bit d_p);
        bit pd;
        if (!d_p) pd = 1'b0;
        else if (!i_p) pd = 1'b1;
`ifdef ARBITER_ROUND_ROBIN_EN
        else pd = !model_last_d;
        model_last_d = pd;
`else
        else pd = 1'b1;
`endif
        return pd;
    endfunction

    task automatic model_reset();
`ifdef ARBITER_ROUND_ROBIN_EN
        model_last_d = 1'b0;
`endif
    endtask

    // Bus monitor: grant history, write-strobe observation, non-granted outputs stay quiet.
    logic [1:0] grant_log[$];
    logic [1:0] prev_grant = 2'b00;
    bit         saw_m_write = 1'b0;
    initial forever begin
        @(negedge clock);
        if (reset) begin
            if (grant != prev_grant && grant != 2'b00) grant_log.push_back(grant);
            if (m_write) saw_m_write = 1'b1;
            n_checks++;
            if ((i_ready && !grant[0]) || ((d_ready || d_done) && !grant[1]) ||
                grant == 2'b11) begin
                n_fail++;
                $display("FAIL monitor_ownership: grant=%b i_ready=%b d_ready=%b d_done=%b",
                         grant, i_ready, d_ready, d_done);
            end
        end
        prev_grant = grant;
    end

    task automatic req_i(input logic [31:0] a, output logic [BW-1:0] data, output int t,
                         output bit ok);
        ok = 1'b0;
        t = 0;
        i_address = a;
        i_read = 1'b1;
        for (int n = 0; n < 100; n++) begin
            @(negedge clock);
            if (i_ready) begin
                ok = 1'b1;
                break;
            end
        end
        data = i_data;
        t = cyc;
        i_read = 1'b0;
        for (int n = 0; n < 100 && i_ready; n++) @(negedge clock);
    endtask

    task automatic req_d(input bit rd, input bit wr, input logic [31:0] a,
                         input logic [BW-1:0] wd, output logic [BW-1:0] data, output int t,
                         output bit got_ready, output bit got_done, output bit ok);
        ok = 1'b0;
        t = 0;
        d_address = a;
        d_wdata = wd;
        d_read = rd;
        d_write = wr;
        for (int n = 0; n < 100; n++) begin
            @(negedge clock);
            if (d_ready || d_done) begin
                ok = 1'b1;
                break;
            end
        end
        data = d_rdata;
        got_ready = d_ready;
        got_done = d_done;
        t = cyc;
        d_read = 1'b0;
        d_write = 1'b0;
        for (int n = 0; n < 100 && (d_ready || d_done); n++) @(negedge clock);
    endtask

    task automatic do_reset();
        i_read = 1'b0;
        d_read = 1'b0;
        d_write = 1'b0;
        reset = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b1;
        model_reset();
        @(negedge clock);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(negedge clock);
        n_checks++;
        if ({m_read, m_write, i_ready, d_ready, d_done} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_strobes: got %b want 00000",
                     {m_read, m_write, i_ready, d_ready, d_done});
        end
        n_checks++;
        if (grant !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_grant: got %b want 00", grant);
        end
        n_checks++;
        if (i_data !== '0 || d_rdata !== '0) begin
            n_fail++;
            $display("FAIL reset_rdata: i_data=%h d_rdata=%h want 0", i_data, d_rdata);
        end
        n_checks++;
        if (m_address !== '0 || m_wdata !== '0) begin
            n_fail++;
            $display("FAIL reset_bus: m_address=%h m_wdata=%h want 0", m_address, m_wdata);
        end
        reset = 1'b1;
        model_reset();
        @(negedge clock);
    endtask

    task automatic test_i_read();
        bit pd;
        pd = model_pick_d(1'b1, 1'b0);
        i_address = 32'h40;
        i_read = 1'b1;
        @(negedge clock);
        n_checks++;
        if (m_read !== 1'b0) begin
            n_fail++;
            $display("FAIL iread_latch_cycle: m_read=%b want 0", m_read);
        end
        @(negedge clock);
        n_checks++;
        if (m_read !== 1'b1 || grant !== 2'b01 || m_address !== 32'h40) begin
            n_fail++;
            $display("FAIL iread_access: m_read=%b grant=%b addr=%h want 1 01 40",
                     m_read, grant, m_address);
        end
        @(negedge clock);
        n_checks++;
        if (i_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL iread_early_ready: i_ready=%b want 0", i_ready);
        end
        @(negedge clock);
        n_checks++;
        if (i_ready !== 1'b1 || i_data !== {32{8'hAA}}) begin
            n_fail++;
            $display("FAIL iread_data: i_ready=%b i_data=%h want 1 AA..AA", i_ready, i_data);
        end
        repeat (3) @(negedge clock);
        n_checks++;
        if (i_ready !== 1'b1 || grant !== 2'b01) begin
            n_fail++;
            $display("FAIL iread_hold: i_ready=%b grant=%b want 1 01", i_ready, grant);
        end
        i_read = 1'b0;
        for (int n = 0; n < 20 && grant != 2'b00; n++) @(negedge clock);
        n_checks++;
        if (grant !== 2'b00 || i_ready !== 1'b0 || i_data !== {32{8'hAA}}) begin
            n_fail++;
            $display("FAIL iread_release: grant=%b i_ready=%b i_data=%h want 00 0 AA..AA",
                     grant, i_ready, i_data);
        end
    endtask

    task automatic test_d_write();
        bit pd, ok;
        int t;
        logic [BW-1:0] data;
        pd = model_pick_d(1'b0, 1'b1);
        d_address = 32'h80;
        d_wdata = 256'h1234;
        d_write = 1'b1;
        for (int n = 0; n < 20 && !m_write; n++) @(negedge clock);
        n_checks++;
        if (m_write !== 1'b1 || m_read !== 1'b0 || m_address !== 32'h80 ||
            m_wdata !== 256'h1234 || grant !== 2'b10) begin
            n_fail++;
            $display("FAIL dwrite_bus: m_write=%b m_read=%b addr=%h wdata=%h grant=%b",
                     m_write, m_read, m_address, m_wdata, grant);
        end
        for (int n = 0; n < 20 && !d_done; n++) @(negedge clock);
        @(negedge clock);
        n_checks++;
        if (d_done !== 1'b1 || d_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL dwrite_done: d_done=%b d_ready=%b want 1 0", d_done, d_ready);
        end
        d_write = 1'b0;
        for (int n = 0; n < 20 && grant != 2'b00; n++) @(negedge clock);
        n_checks++;
        if (d_done !== 1'b0 || grant !== 2'b00) begin
            n_fail++;
            $display("FAIL dwrite_release: d_done=%b grant=%b want 0 00", d_done, grant);
        end
        ref_write(32'h80, 256'h1234);
        pd = model_pick_d(1'b1, 1'b0);
        req_i(32'h80, data, t, ok);
        n_checks++;
        if (!ok || data !== ref_rd(32'h80)) begin
            n_fail++;
            $display("FAIL dwrite_readback: ok=%0d data=%h want %h", ok, data, ref_rd(32'h80));
        end
    endtask

    task automatic test_simultaneous(input int reps);
        logic [31:0]   ai, ad;
        logic [BW-1:0] di, dd;
        logic [1:0]    exp_log[$];
        int            ti, td;
        bit            oki, okd, gr, gd, pd;
        grant_log.delete();
        for (int r = 0; r < reps; r++) begin
            ai = 32'(r) << 5;
            ad = 32'(r + 4) << 5;
            pd = model_pick_d(1'b1, 1'b1);
            exp_log.push_back(pd ? 2'b10 : 2'b01);
            exp_log.push_back(pd ? 2'b01 : 2'b10);
            void'(model_pick_d(!pd, pd));
            fork
                req_i(ai, di, ti, oki);
                req_d(1'b1, 1'b0, ad, '0, dd, td, gr, gd, okd);
            join
            n_checks++;
            if (!oki || !okd || di !== ref_rd(ai) || dd !== ref_rd(ad)) begin
                n_fail++;
                $display("FAIL simul_data[%0d]: ok=%0d%0d i=%h d=%h want %h %h", r, oki, okd,
                         di, dd, ref_rd(ai), ref_rd(ad));
            end
            n_checks++;
            if ((pd && !(td < ti)) || (!pd && !(ti < td))) begin
                n_fail++;
                $display("FAIL simul_order[%0d]: i_cycle=%0d d_cycle=%0d want %s first", r, ti,
                         td, pd ? "D" : "I");
            end
        end
        n_checks++;
        if (grant_log.size() != exp_log.size()) begin
            n_fail++;
            $display("FAIL simul_grant_count: got %0d want %0d", grant_log.size(),
                     exp_log.size());
        end else begin
            for (int k = 0; k < exp_log.size(); k++) begin
                n_checks++;
                if (grant_log[k] !== exp_log[k]) begin
                    n_fail++;
                    $display("FAIL simul_grant[%0d]: got %b want %b", k, grant_log[k],
                             exp_log[k]);
                end
            end
        end
    endtask

    task automatic test_read_write_both();
        logic [BW-1:0] dd;
        int            td;
        bit            gr, gd, ok, pd;
        pd = model_pick_d(1'b0, 1'b1);
        saw_m_write = 1'b0;
        req_d(1'b1, 1'b1, 32'h60, {8{32'hDEAD_BEEF}}, dd, td, gr, gd, ok);
        n_checks++;
        if (!ok || gr !== 1'b1 || gd !== 1'b0) begin
            n_fail++;
            $display("FAIL rdwr_resp: ok=%0d d_ready=%b d_done=%b want 1 1 0", ok, gr, gd);
        end
        n_checks++;
        if (dd !== ref_rd(32'h60)) begin
            n_fail++;
            $display("FAIL rdwr_data: got %h want %h", dd, ref_rd(32'h60));
        end
        n_checks++;
        if (saw_m_write !== 1'b0) begin
            n_fail++;
            $display("FAIL rdwr_no_write: m_write seen=%b want 0", saw_m_write);
        end
    endtask

    task automatic test_reset_mid();
        logic [BW-1:0] di;
        int            ti;
        bit            ok, pd;
        pd = model_pick_d(1'b1, 1'b0);
        i_address = 32'h20;
        i_read = 1'b1;
        for (int n = 0; n < 20 && !m_read; n++) @(negedge clock);
        n_checks++;
        if (m_read !== 1'b1) begin
            n_fail++;
            $display("FAIL rstmid_access: m_read=%b want 1", m_read);
        end
        #2 reset = 1'b0;
        #1;
        n_checks++;
        if ({m_read, i_ready, d_ready, d_done} !== 4'b0 || grant !== 2'b00) begin
            n_fail++;
            $display("FAIL rstmid_async: strobes=%b grant=%b want 0000 00",
                     {m_read, i_ready, d_ready, d_done}, grant);
        end
        @(negedge clock);
        i_read = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        model_reset();
        repeat (2) @(negedge clock);
        pd = model_pick_d(1'b1, 1'b0);
        req_i(32'h20, di, ti, ok);
        n_checks++;
        if (!ok || di !== ref_rd(32'h20)) begin
            n_fail++;
            $display("FAIL rstmid_after: ok=%0d data=%h want %h", ok, di, ref_rd(32'h20));
        end
    endtask

    task automatic test_random(input int iters);
        logic [31:0]   ai, ad;
        logic [BW-1:0] wd, di, dd, exp_i, exp_d;
        int            mode, ti, td;
        bit            i_act, d_act, dwr, pd, oki, okd, gr, gd;
        for (int it = 0; it < iters; it++) begin
            mode = int'($urandom_range(0, 3));
            ai = 32'($urandom_range(0, 7)) << 5;
            ad = 32'($urandom_range(0, 7)) << 5;
            wd = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom,
                  $urandom};
            i_act = (mode == 0) || (mode == 3);
            d_act = (mode != 0);
            dwr = (mode == 2) || (mode == 3 && $urandom_range(0, 1) == 1);
            pd = model_pick_d(i_act, d_act);
            if (i_act && d_act) void'(model_pick_d(!pd, pd));
            // Apply operations in predicted service order.
            exp_i = '0;
            exp_d = '0;
            if (pd || !i_act) begin
                if (d_act) begin
                    if (dwr) ref_write(ad, wd);
                    else exp_d = ref_rd(ad);
                end
                if (i_act) exp_i = ref_rd(ai);
            end else begin
                exp_i = ref_rd(ai);
                if (d_act) begin
                    if (dwr) ref_write(ad, wd);
                    else exp_d = ref_rd(ad);
                end
            end
            oki = 1'b1;
            okd = 1'b1;
            gr = 1'b0;
            gd = 1'b0;
            di = '0;
            dd = '0;
            ti = 0;
            td = 0;
            fork
                begin
                    if (i_act) req_i(ai, di, ti, oki);
                end
                begin
                    if (d_act) req_d(!dwr, dwr, ad, wd, dd, td, gr, gd, okd);
                end
            join
            n_checks++;
            if (!oki || !okd) begin
                n_fail++;
                $display("FAIL rand_timeout[%0d]: i_ok=%0d d_ok=%0d", it, oki, okd);
            end
            if (i_act) begin
                n_checks++;
                if (di !== exp_i) begin
                    n_fail++;
                    $display("FAIL rand_i_data[%0d]: got %h want %h", it, di, exp_i);
                end
            end
            if (d_act) begin
                n_checks++;
                if (gr !== !dwr || gd !== dwr || (!dwr && dd !== exp_d)) begin
                    n_fail++;
                    $display("FAIL rand_d_resp[%0d]: ready=%b done=%b data=%h want %b %b %h",
                             it, gr, gd, dd, !dwr, dwr, exp_d);
                end
            end
            if (i_act && d_act) begin
                n_checks++;
                if ((pd && !(td < ti)) || (!pd && !(ti < td))) begin
                    n_fail++;
                    $display("FAIL rand_order[%0d]: i_cycle=%0d d_cycle=%0d want %s first", it,
                             ti, td, pd ? "D" : "I");
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_i_read();
        test_d_write();
        test_simultaneous(1);
        do_reset();
        test_simultaneous(4);
        test_read_write_both();
        test_reset_mid();
        test_random(40);
        repeat (3) @(negedge clock);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
